// File: rtl/branch_pc_unit_if.sv
// Instruction-fetch handshake between the branch/PC stage (master) and instruction memory (slave).
interface branch_pc_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        if_valid;

  modport master (output imem_req, output imem_addr, output if_valid, input imem_ready);
  modport slave  (input imem_req, input imem_addr, input if_valid, output imem_ready);
endinterface

// File: rtl/branch_pc_unit.sv
// Branch resolution, PC register and fetch FSM; redirect/flush/misalign_err land one cycle after the deciding edge.
// Backpressure: imem_ready low holds imem_addr; stall holds the PC but never blocks a redirect.
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_is_jal,
  input  logic             ex_is_jalr,
  input  logic [2:0]       ex_funct3,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_imm,
  input  logic [31:0]      ex_rs1,
  input  logic             BrEq,
  input  logic             BrLT,
  output logic             BrUn,
  branch_pc_unit_if.master imem,
  output logic             flush,
  output logic             misalign_err,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] br_taken_cnt
);

  typedef enum logic [1:0] {FETCH, WAIT, REDIR} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] redir_pc;
  logic        cond;
  logic        legal;
  logic        take;
  logic        misaligned;
  logic        redirect;
  logic        count_br;
  logic [31:0] sum;
  logic [31:0] target;

  always_comb begin
    cond  = 1'b0;
    legal = 1'b1;
    case (ex_funct3)
      3'b000:         cond = BrEq;
      3'b001:         cond = ~BrEq;
      3'b100, 3'b110: cond = BrLT;
      3'b101, 3'b111: cond = ~BrLT;
      default:        legal = 1'b0;
    endcase
  end

  assign BrUn       = ex_funct3[1];
  assign take       = ex_valid & ((ex_is_branch & cond) | ex_is_jal | ex_is_jalr);
  assign sum        = (ex_is_jalr ? ex_rs1 : ex_pc) + ex_imm;
  assign target     = ex_is_jalr ? {sum[31:1], 1'b0} : sum;
  assign misaligned = |target[1:0];
  assign redirect   = take & ~misaligned;
  assign count_br   = ex_valid & ex_is_branch & legal;

  // Request is held high in every state; only reset withdraws it.
  assign imem.imem_req  = ~rst;
  assign imem.imem_addr = pc;
  assign imem.if_valid  = imem.imem_ready & (state != REDIR) & ~take & ~stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      redir_pc     <= 32'h0;
      flush        <= 1'b0;
      misalign_err <= 1'b0;
      br_cnt       <= '0;
      br_taken_cnt <= '0;
    end else begin
      flush        <= 1'b0;
      misalign_err <= take & misaligned;
      case (state)
        FETCH: begin
          if (redirect) begin
            pc    <= target;
            flush <= 1'b1;
          end else if (imem.imem_ready && !stall) begin
            pc <= pc + 32'd4;
          end else if (!imem.imem_ready) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          // A redirect during an outstanding fetch must wait for that response to drain.
          if (redirect) begin
            redir_pc <= target;
            state    <= REDIR;
          end else if (imem.imem_ready) begin
            state <= FETCH;
            if (!stall) pc <= pc + 32'd4;
          end
        end
        REDIR: begin
          if (imem.imem_ready) begin
            pc    <= redir_pc;
            flush <= 1'b1;
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
      if (count_br) begin
        if (br_cnt != {CNT_W{1'b1}}) br_cnt <= br_cnt + 1'b1;
        if (cond && br_taken_cnt != {CNT_W{1'b1}}) br_taken_cnt <= br_taken_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed-vector bench for branch_pc_unit with hand-computed expectations.
module tb_branch_pc_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall, ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_pc, ex_imm, ex_rs1;
  logic        BrEq, BrLT, BrUn, flush, misalign_err;
  logic [15:0] br_cnt, br_taken_cnt;
  int          checks = 0;
  int          failures = 0;

  branch_pc_unit_if imem();

  branch_pc_unit #(.RESET_PC(32'h0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid),
    .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
    .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
    .BrEq(BrEq), .BrLT(BrLT), .BrUn(BrUn), .imem(imem), .flush(flush),
    .misalign_err(misalign_err), .br_cnt(br_cnt), .br_taken_cnt(br_taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0;
    ex_funct3 = 3'b000; ex_pc = 0; ex_imm = 0; ex_rs1 = 0; BrEq = 0; BrLT = 0;
  endtask

  task automatic set_br(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                        input logic eq, input logic lt);
    clear_ex();
    ex_valid = 1; ex_is_branch = 1; ex_funct3 = f3; ex_pc = pc; ex_imm = imm; BrEq = eq; BrLT = lt;
  endtask

  initial begin
    rst = 1; stall = 0; imem.imem_ready = 1;
    clear_ex();
    #2;
    chk("rst_req", 32'(imem.imem_req), 32'd0);
    chk("rst_addr", imem.imem_addr, 32'h0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_cnt", 32'(br_cnt), 32'd0);
    #10;
    rst = 0;
    #1;
    // Sequential fetch out of reset
    chk("seq_req", 32'(imem.imem_req), 32'd1);
    chk("seq_addr0", imem.imem_addr, 32'h0);
    step(); chk("seq_addr4", imem.imem_addr, 32'h4); chk("seq_flush4", 32'(flush), 32'd0);
    step(); chk("seq_addr8", imem.imem_addr, 32'h8); chk("seq_flush8", 32'(flush), 32'd0);
    step(); chk("seq_addrC", imem.imem_addr, 32'hC); chk("seq_flushC", 32'(flush), 32'd0);

    // Taken BEQ
    set_br(3'b000, 32'h100, 32'h40, 1, 0);
    #1; chk("beq_ifv", 32'(imem.if_valid), 32'd0);
    step();
    chk("beq_pc", imem.imem_addr, 32'h140);
    chk("beq_flush", 32'(flush), 32'd1);
    chk("beq_cnt", 32'(br_cnt), 32'd1);
    chk("beq_tcnt", 32'(br_taken_cnt), 32'd1);
    clear_ex();
    step();
    chk("beq_flush_drop", 32'(flush), 32'd0);
    chk("beq_pc_next", imem.imem_addr, 32'h144);

    // BLTU not taken, then an illegal funct3
    set_br(3'b110, 32'h200, 32'h20, 0, 0);
    #1; chk("bltu_brun", 32'(BrUn), 32'd1);
    step();
    chk("bltu_pc", imem.imem_addr, 32'h148);
    chk("bltu_flush", 32'(flush), 32'd0);
    chk("bltu_cnt", 32'(br_cnt), 32'd2);
    chk("bltu_tcnt", 32'(br_taken_cnt), 32'd1);
    set_br(3'b010, 32'h200, 32'h20, 1, 1);
    #1; chk("ill_brun", 32'(BrUn), 32'd1);
    step();
    chk("ill_pc", imem.imem_addr, 32'h14C);
    chk("ill_flush", 32'(flush), 32'd0);
    chk("ill_cnt", 32'(br_cnt), 32'd2);
    chk("ill_tcnt", 32'(br_taken_cnt), 32'd1);

    // JALR clears bit 0; JAL to a half-word target faults instead of redirecting
    clear_ex(); ex_valid = 1; ex_is_jalr = 1; ex_rs1 = 32'h2001; ex_imm = 32'h3;
    step();
    chk("jalr_pc", imem.imem_addr, 32'h2004);
    chk("jalr_flush", 32'(flush), 32'd1);
    chk("jalr_mis", 32'(misalign_err), 32'd0);
    clear_ex(); ex_valid = 1; ex_is_jal = 1; ex_pc = 32'h300; ex_imm = 32'h2;
    step();
    chk("jal_mis", 32'(misalign_err), 32'd1);
    chk("jal_mis_flush", 32'(flush), 32'd0);
    chk("jal_mis_pc", imem.imem_addr, 32'h2008);
    clear_ex();
    step();
    chk("jal_mis_drop", 32'(misalign_err), 32'd0);
    chk("jal_mis_pc2", imem.imem_addr, 32'h200C);

    // Redirect while a fetch is outstanding
    imem.imem_ready = 0;
    step(); chk("wait_addr1", imem.imem_addr, 32'h200C);
    clear_ex(); ex_valid = 1; ex_is_jal = 1; ex_pc = 32'h400; ex_imm = 32'h80;
    step(); chk("wait_addr2", imem.imem_addr, 32'h200C); chk("wait_flush2", 32'(flush), 32'd0);
    clear_ex();
    step(); chk("redir_addr", imem.imem_addr, 32'h200C); chk("redir_flush", 32'(flush), 32'd0);
    imem.imem_ready = 1;
    #1; chk("redir_ifv", 32'(imem.if_valid), 32'd0);
    step(); chk("redir_pc", imem.imem_addr, 32'h480); chk("redir_flush_on", 32'(flush), 32'd1);
    step(); chk("redir_pc_next", imem.imem_addr, 32'h484); chk("redir_flush_off", 32'(flush), 32'd0);

    // Stall holds PC but not a redirect
    stall = 1;
    #1; chk("stall_ifv", 32'(imem.if_valid), 32'd0);
    step(); chk("stall_pc", imem.imem_addr, 32'h484);
    set_br(3'b000, 32'h500, 32'h10, 1, 0);
    step();
    chk("stall_br_pc", imem.imem_addr, 32'h510);
    chk("stall_br_flush", 32'(flush), 32'd1);
    chk("stall_br_cnt", 32'(br_cnt), 32'd3);
    stall = 0;

    // Saturate both counters
    set_br(3'b000, 32'h600, 32'h0, 1, 0);
    for (int i = 0; i < 65536; i++) step();
    chk("sat_cnt", 32'(br_cnt), 32'hFFFF);
    chk("sat_tcnt", 32'(br_taken_cnt), 32'hFFFF);
    set_br(3'b000, 32'h600, 32'h0, 1, 0);
    step();
    chk("sat_cnt_hold", 32'(br_cnt), 32'hFFFF);
    chk("sat_tcnt_hold", 32'(br_taken_cnt), 32'hFFFF);
    clear_ex();
    step(); chk("post_sat_pc", imem.imem_addr, 32'h604);

    // Reset asserted mid-WAIT
    imem.imem_ready = 0;
    step(); chk("rw_addr", imem.imem_addr, 32'h604);
    #2 rst = 1;
    #1;
    chk("rw_rst_addr", imem.imem_addr, 32'h0);
    chk("rw_rst_req", 32'(imem.imem_req), 32'd0);
    chk("rw_rst_cnt", 32'(br_cnt), 32'd0);
    chk("rw_rst_tcnt", 32'(br_taken_cnt), 32'd0);
    step();
    rst = 0; imem.imem_ready = 1;
    step(); chk("rw_restart", imem.imem_addr, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
